nf10_axis_pkt_gen: RTL and testbench
====================================

Name: nf10_axis_pkt_gen

Overview:
Synthesizable AXI4-Stream packet generator (master). It is the stimulus end of the port interface whose TX side the nf10g port checkers consume. Sits in place of a 10G port RX output, feeding input_arbiter / rldram_stream RX path in simulation and on hardware. Payload is deterministic so the downstream checker can regenerate it from sequence number and beat index.

Parameters:
C_M_AXIS_DATA_WIDTH, 64, data width; fixed 64 (tkeep 8 bits)
C_M_AXIS_TUSER_WIDTH, 128, NetFPGA tuser width
C_SRC_PORT, 8'h01, tuser[23:16] one-hot source port
C_DST_PORT, 8'h00, tuser[31:24] destination port
C_MAX_LEN, 1514, upper clamp on packet byte length

Ports:
axi_aclk  in  1  clock
axi_reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; launches a run when idle
abort  in  1  level; stop after current packet
pkt_count  in  16  packets per run, latched on start
pkt_len  in  16  bytes per packet, latched on start
ipg  in  8  idle cycles between packets, latched on start
m_axis_tdata  out  64  payload
m_axis_tkeep  out  8  byte enables, bit0 = byte0
m_axis_tuser  out  128  {96'b0, C_DST_PORT, C_SRC_PORT, len[15:0]}
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of packet
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
pkts_sent  out  32  packets completed since reset (wraps)
stall_cnt  out  32  backpressure cycles (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Reset mid-packet drops the packet immediately; no tlast is emitted.
- Length clamp on latch: len < 60 -> 60; len > C_MAX_LEN -> C_MAX_LEN.
- Beats = ceil(len/8). r = len mod 8. Last-beat tkeep = 8'hFF if r == 0, else (1<<r)-1. Non-last beats use 8'hFF.
- Data for beat b (0-based) of packet s (0-based within run, 32-bit): {s, b}, with s in [63:32] and b in [31:0].
- tuser is constant for the whole packet.
- FSM states: IDLE, SEND, GAP.
  - IDLE: start with pkt_count == 0 -> done pulse next cycle; busy stays 0. start with count > 0 -> SEND; busy = 1 and tvalid = 1 on the cycle after start (latency 1).
  - SEND: a beat advances only on tvalid & tready. tdata/tkeep/tlast/tuser are held stable while tvalid & !tready. tvalid never drops mid-packet.
  - On the accepted tlast beat: pkts_sent++. Then:
    - if packets done == count or abort is high -> IDLE, with done pulsed the next cycle and busy cleared in the same cycle;
    - else if ipg == 0 -> next packet's first beat is presented the next cycle (back-to-back);
    - else -> GAP.
  - GAP: tvalid = 0 for exactly ipg cycles, then SEND. abort high in GAP -> IDLE plus done pulse.
- start while busy is ignored; inputs are not re-latched.
- abort in IDLE has no effect. abort never truncates a packet.
- start and abort in the same IDLE cycle: start wins; the run emits exactly one packet and ends.

Optional Feature:
NF10_PKT_GEN_STATS_EN
- Defined: stall_cnt increments every cycle with tvalid & !tready. It saturates at 32'hFFFFFFFF and clears only on reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Package nf10_axis_pkg holds:
  - tuser field offsets (LEN_LO = 0, SRC_LO = 16, DST_LO = 24);
  - MIN_PKT_LEN = 60;
  - a function for last-beat tkeep from the length's low 3 bits;
  - the FSM state enum.
- The package is shared with the port checkers.
- No sub-module: the FSM plus counters form a single module.

Test Plan:
1. start, count = 1, len = 60, ipg = 0, tready = 1 -> 8 beats; beat 7 has tkeep 8'h0F and tlast; tuser[15:0] = 60; done 1 cycle after tlast; pkts_sent = 1.
2. count = 3, len = 65, ipg = 4 -> 9 beats per packet with last tkeep 8'h01; exactly 4 idle cycles between packets; tdata[63:32] = 0, 1, 2.
3. len = 64, tready toggling 1,0,0,1 repeating -> data held across stalls; 8 beats with final tkeep 8'hFF; stall_cnt = stall cycles with STATS_EN defined, 0 without.
4. count = 100, assert abort during packet 2 -> packet 2 completes with tlast; no packet 3; done pulse; pkts_sent = 3.
5. len = 10 and len = 4000 -> clamped to 60 and 1514 (190 beats, last tkeep 8'h03); count = 0 -> done only, tvalid never high.
6. axi_reset mid-packet at beat 3 -> all outputs 0 asynchronously; after release, a new start gives a fresh packet with s = 0, b = 0.

Source files
------------

// File: rtl/nf10_axis_pkg.sv
// Shared NetFPGA AXI-Stream definitions used by the packet generator and the port checkers.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package nf10_axis_pkg;

  // tuser bit offsets of the NetFPGA metadata fields
  localparam int LEN_LO = 0;
  localparam int SRC_LO = 16;
  localparam int DST_LO = 24;

  // Shortest legal Ethernet frame without FCS
  localparam int MIN_PKT_LEN = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } pkt_gen_state_e;

  // Byte enables of the final beat given the packet length's low 3 bits
  function automatic logic [7:0] last_tkeep(input logic [2:0] len_lo3);
    logic [7:0] one;
    one = 8'h01;
    if (len_lo3 == 3'd0) return 8'hFF;
    return (one << len_lo3) - 8'h01;
  endfunction

endpackage

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream packet generator: runs of deterministic packets ({seq, beat} payload); optional stall counter under NF10_PKT_GEN_STATS_EN.
// Latency: first beat is presented the cycle after start; done pulses the cycle after the final tlast is accepted.
// Backpressure: beats advance only on tvalid & tready; all beat fields hold while stalled, tvalid never drops mid-packet.
module nf10_axis_pkt_gen
  import nf10_axis_pkg::*;
#(
  parameter int         C_M_AXIS_DATA_WIDTH  = 64,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT           = 8'h01,
  parameter logic [7:0] C_DST_PORT           = 8'h00,
  parameter int         C_MAX_LEN            = 1514
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [15:0]                       pkt_count,
  input  logic [15:0]                       pkt_len,
  input  logic [7:0]                        ipg,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       pkts_sent,
  output logic [31:0]                       stall_cnt
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_PKT_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(C_MAX_LEN);

  pkt_gen_state_e state_q, state_d;
  logic           done_d, done_q;
  logic [15:0]    cnt_q, len_q, last_idx_q, len_clamp;
  logic [7:0]     ipg_q, gap_q, last_keep_q;
  logic [31:0]    pkt_idx_q, beat_q, pkts_sent_q;
  logic           abort_q;
  logic           send, accept, last_beat, run_over;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_w;

  assign send      = (state_q == ST_SEND);
  assign accept    = send & m_axis_tready;
  assign last_beat = (beat_q == {16'h0, last_idx_q});
  // Abort requests are sticky so a short pulse (even one coinciding with start) still ends the run
  assign run_over  = ((pkt_idx_q + 32'd1) == {16'h0, cnt_q}) | abort | abort_q;
  assign len_clamp = (pkt_len < MIN_LEN16) ? MIN_LEN16 :
                     (pkt_len > MAX_LEN16) ? MAX_LEN16 : pkt_len;

  // State and done-pulse registers
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state and run-end decision
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pkt_count == 16'd0) done_d  = 1'b1;
          else                    state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept && last_beat) begin
          if (run_over) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (ipg_q != 8'd0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort || abort_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == 8'd1) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration latch, beat/packet/gap counters and the completed-packet counter
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      cnt_q       <= '0;
      len_q       <= '0;
      ipg_q       <= '0;
      last_idx_q  <= '0;
      last_keep_q <= '0;
      pkt_idx_q   <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      abort_q     <= 1'b0;
      pkts_sent_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            cnt_q       <= pkt_count;
            len_q       <= len_clamp;
            ipg_q       <= ipg;
            last_idx_q  <= (len_clamp - 16'd1) >> 3;
            last_keep_q <= last_tkeep(len_clamp[2:0]);
            pkt_idx_q   <= '0;
            beat_q      <= '0;
            abort_q     <= abort;
          end
        end
        ST_SEND: begin
          if (abort) abort_q <= 1'b1;
          if (accept) begin
            if (last_beat) begin
              beat_q      <= '0;
              pkt_idx_q   <= pkt_idx_q + 32'd1;
              gap_q       <= ipg_q;
              pkts_sent_q <= pkts_sent_q + 32'd1;
            end else begin
              beat_q <= beat_q + 32'd1;
            end
          end
        end
        ST_GAP: begin
          if (abort) abort_q <= 1'b1;
          gap_q <= gap_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // tuser is only driven while a packet is on the bus so reset leaves every output at zero
  always_comb begin
    tuser_w = '0;
    if (send) begin
      tuser_w[LEN_LO +: 16] = len_q;
      tuser_w[SRC_LO +: 8]  = C_SRC_PORT;
      tuser_w[DST_LO +: 8]  = C_DST_PORT;
    end
  end

  assign m_axis_tvalid = send;
  assign m_axis_tdata  = send ? {pkt_idx_q, beat_q} : '0;
  assign m_axis_tkeep  = send ? (last_beat ? last_keep_q : 8'hFF) : 8'h00;
  assign m_axis_tlast  = send & last_beat;
  assign m_axis_tuser  = tuser_w;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign pkts_sent     = pkts_sent_q;

`ifdef NF10_PKT_GEN_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the sink held off a valid beat
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) stall_q <= '0;
    else if (send && !m_axis_tready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Self-checking bench for nf10_axis_pkt_gen: table of runs plus reset, busy-start and idle-abort sequences.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Backpressure: tready driven always-high, 1-0-0-1 pattern or random per table entry.
module tb_nf10_axis_pkt_gen;

  logic         clk, axi_reset, start, abort, m_axis_tready;
  logic [15:0]  pkt_count, pkt_len;
  logic [7:0]   ipg;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tlast, busy, done;
  logic [31:0]  pkts_sent, stall_cnt;

  nf10_axis_pkt_gen dut (
    .axi_aclk(clk), .axi_reset(axi_reset), .start(start), .abort(abort),
    .pkt_count(pkt_count), .pkt_len(pkt_len), .ipg(ipg),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cnt, len, ipg, mode, abort_pkt;
    int         exp_len, exp_beats;
    logic [7:0] exp_keep;
    int         exp_pkts;
  } vec_t;

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[10];
  int    errors = 0, checks = 0;
  int    cyc = 0, cur_mode = 0, cur_ipg = 0, abort_pkt = -1;
  int    done_seen = 0, gap_cnt = 0, pkts_model = 0, stall_model = 0;
  bit    valid_seen = 0, gap_pending = 0, exp_done_next = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample, score, then set tready/abort for the next edge
  task automatic cycle();
    beat_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_done_next) begin
      chk("done_after_tlast", 256'(done), 256'(1));
      chk("busy_clear_at_done", 256'(busy), 256'(0));
      exp_done_next = 0;
    end
    if (done) done_seen++;
    if (m_axis_tvalid) valid_seen = 1;
    if (gap_pending) begin
      if (m_axis_tvalid) begin
        chk("ipg_cycles", 256'(gap_cnt), 256'(cur_ipg));
        gap_pending = 0;
      end else begin
        gap_cnt++;
      end
    end
    case (cur_mode)
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
    if (m_axis_tvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 256'(m_axis_tvalid), 256'(0));
      end else begin
        e = sb[0];
        chk("beat", 256'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 256'(e));
        if (m_axis_tready) begin
          void'(sb.pop_front());
          if (m_axis_tlast) begin
            if (sb.size() == 0) exp_done_next = 1;
            else begin
              gap_pending = 1;
              gap_cnt = 0;
            end
          end
        end
      end
      if (!m_axis_tready) stall_model++;
      if (abort_pkt >= 0 && m_axis_tdata[63:32] == 32'(abort_pkt)) abort = 1'b1;
    end
  endtask

  task automatic start_run(input vec_t v);
    beat_t e;
    cur_mode = v.mode; cur_ipg = v.ipg; abort_pkt = v.abort_pkt;
    done_seen = 0; valid_seen = 0; gap_pending = 0;
    for (int s = 0; s < v.exp_pkts; s++)
      for (int b = 0; b < v.exp_beats; b++) begin
        e.d = {32'(s), 32'(b)};
        e.l = (b == v.exp_beats - 1);
        e.k = e.l ? v.exp_keep : 8'hFF;
        e.u = {96'h0, 8'h00, 8'h01, 16'(v.exp_len)};
        sb.push_back(e);
      end
    pkts_model += v.exp_pkts;
    pkt_count = 16'(v.cnt); pkt_len = 16'(v.len); ipg = 8'(v.ipg);
    start = 1'b1;
    if (v.abort_pkt == -2) abort = 1'b1;
    if (v.cnt == 0) exp_done_next = 1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(v.cnt != 0));
    chk("tvalid_after_start", 256'(m_axis_tvalid), 256'(v.cnt != 0));
  endtask

  task automatic run_case(input vec_t v, input bit poke);
    int exp_stall;
    start_run(v);
    for (int k = 0; k < 4000 && done_seen == 0; k++) begin
      if (poke && k == 5) begin
        start = 1'b1; pkt_count = 16'd7; pkt_len = 16'd200; ipg = 8'd0;
      end else begin
        start = 1'b0;
      end
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    if (done_seen == 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no done expected done within 4000 cycles");
    end
    repeat (2) cycle();
`ifdef NF10_PKT_GEN_STATS_EN
    exp_stall = stall_model;
`else
    exp_stall = 0;
`endif
    chk("done_single_pulse", 256'(done_seen), 256'(1));
    chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    chk("pkts_sent", 256'(pkts_sent), 256'(pkts_model));
    chk("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
    chk("tvalid_seen", 256'(valid_seen), 256'(v.cnt != 0));
  endtask

  initial begin
    vec_t v;
    start = 0; abort = 0; m_axis_tready = 1; pkt_count = 0; pkt_len = 0; ipg = 0;
    axi_reset = 1'b1;
    #3;
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_busy_done", 256'({busy, done, m_axis_tlast}), 256'(0));
    chk("rst_data", 256'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 256'(0));
    chk("rst_counters", 256'({pkts_sent, stall_cnt}), 256'(0));

    //          cnt  len   ipg mode abort exp_len beats keep   pkts
    vecs[0] = '{1,   60,   0,  0,   -1,   60,     8,    8'h0F, 1};
    vecs[1] = '{3,   65,   4,  0,   -1,   65,     9,    8'h01, 3};
    vecs[2] = '{1,   64,   0,  1,   -1,   64,     8,    8'hFF, 1};
    vecs[3] = '{100, 100,  2,  0,    2,   100,    13,   8'h0F, 3};
    vecs[4] = '{1,   10,   0,  0,   -1,   60,     8,    8'h0F, 1};
    vecs[5] = '{1,   4000, 0,  2,   -1,   1514,   190,  8'h03, 1};
    vecs[6] = '{0,   100,  0,  0,   -1,   100,    13,   8'h0F, 0};
    vecs[7] = '{5,   61,   0,  2,   -1,   61,     8,    8'h1F, 5};
    vecs[8] = '{2,   100,  1,  0,   -2,   100,    13,   8'h0F, 1};
    vecs[9] = '{2,   1514, 3,  1,   -1,   1514,   190,  8'h03, 2};

    @(negedge clk);
    @(negedge clk);
    axi_reset = 1'b0;

    foreach (vecs[i]) run_case(vecs[i], 1'b0);

    // start while busy is ignored
    v = '{2, 60, 1, 0, -1, 60, 8, 8'h0F, 2};
    run_case(v, 1'b1);

    // abort in IDLE does nothing
    done_seen = 0; valid_seen = 0;
    abort = 1'b1;
    repeat (3) cycle();
    abort = 1'b0;
    chk("idle_abort_busy", 256'({busy, m_axis_tvalid}), 256'(0));
    chk("idle_abort_done", 256'(done_seen), 256'(0));

    // reset while beat 3 of a packet is on the bus
    v = '{1, 100, 0, 0, -1, 100, 13, 8'h0F, 1};
    start_run(v);
    for (int k = 0; k < 50 && sb.size() > 10; k++) cycle();
    cycle();
    chk("beat3_on_bus", 256'({m_axis_tvalid, m_axis_tdata}), 256'({1'b1, 64'd3}));
    #2 axi_reset = 1'b1;
    #1;
    chk("async_rst_outputs", 256'({m_axis_tvalid, m_axis_tlast, busy, done, m_axis_tkeep}), 256'(0));
    chk("async_rst_data", 256'({m_axis_tdata, m_axis_tuser}), 256'(0));
    chk("async_rst_counters", 256'({pkts_sent, stall_cnt}), 256'(0));
    sb.delete();
    pkts_model = 0; stall_model = 0; exp_done_next = 0; gap_pending = 0;
    @(negedge clk);
    axi_reset = 1'b0;
    run_case(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
